// File: rtl/bin_to_bcd_if.sv
// Start/busy/done handshake bundle for the binary-to-BCD converter.
// master drives start/bin; slave returns status and result.
interface bin_to_bcd_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 2
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (
        output start, bin,
        input  busy, done, bcd, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, ovf
    );
endinterface

// File: rtl/bin_to_bcd.sv
// Sequential binary to packed BCD converter (double dabble, 1 bit/clk).
// Optional macro BCD_SAT_EN: saturate bcd to all 9s on overflow.
module bin_to_bcd #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    bin_to_bcd_if.slave  bus
);
    function automatic int dig_cnt(input int w);
        logic [63:0] v;
        int          d;
        v = (64'd1 << w) - 64'd1;
        d = 0;
        do begin
            v = v / 64'd10;
            d++;
        end while (v != 64'd0);
        return d;
    endfunction

    localparam int DIG_INT = dig_cnt(BIN_W);
    localparam int ACC_W   = 4 * DIG_INT;
    localparam int OUT_W   = 4 * DIGITS;
    localparam int FW      = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int CNT_W   = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [BIN_W-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic               done_q;
    logic [OUT_W-1:0]   bcd_q;
    logic               ovf_q;

    logic [ACC_W-1:0]       acc_adj;
    logic [ACC_W+BIN_W-1:0] shifted;
    logic [ACC_W-1:0]       acc_next;
    logic [FW-1:0]          full_next;
    logic                   ovf_next;
    logic [OUT_W-1:0]       bcd_next;

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIG_INT; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        shifted   = {acc_adj, shreg} << 1;
        acc_next  = shifted[ACC_W+BIN_W-1:BIN_W];
        full_next = FW'(acc_next);
        // Any nonzero digit above the presented ones means overflow.
        ovf_next  = (full_next >> OUT_W) != '0;
`ifdef BCD_SAT_EN
        bcd_next  = ovf_next ? {DIGITS{4'h9}}
                             : full_next[OUT_W-1:0];
`else
        bcd_next  = full_next[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            shreg  <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        shreg  <= bus.bin;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= CONV;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                CONV: begin
                    {acc, shreg} <= shifted;
                    cnt          <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        bcd_q  <= bcd_next;
                        ovf_q  <= ovf_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
    assign bus.ovf  = ovf_q;
endmodule
